// File: rtl/alu_pkg.sv
// Shared definitions for the bit-serial ALU sequencer: opcodes, slice ops, FSM states, decode.
// Optional feature macro: ALU_SERIAL_SLT_EN (enables the SLT set-bit patch).
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_ADD  = 2'b10;
  localparam logic [1:0] OP_LESS = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  typedef struct packed {
    logic       a_inv;
    logic       b_inv;
    logic [1:0] op;
    logic       cin;
    logic       arith;
`ifdef ALU_SERIAL_SLT_EN
    logic       slt;
`endif
  } dec_t;

  function automatic dec_t alu_decode(input logic [3:0] ctrl);
    dec_t d;
    d = '0;
    case (ctrl)
      ALU_AND, ALU_OR, ALU_NOR: begin
        d.a_inv = ctrl[3];
        d.b_inv = ctrl[2];
        d.op    = ctrl[1:0];
      end
      ALU_ADD: begin
        d.op    = OP_ADD;
        d.arith = 1'b1;
      end
      ALU_SUB: begin
        d.b_inv = 1'b1;
        d.op    = OP_ADD;
        d.cin   = 1'b1;
        d.arith = 1'b1;
      end
      ALU_SLT: begin
        // SLT streams the full difference so the MSB sum is available for the set bit.
        d.b_inv = 1'b1;
        d.op    = OP_ADD;
        d.cin   = 1'b1;
        d.arith = 1'b1;
`ifdef ALU_SERIAL_SLT_EN
        d.slt   = 1'b1;
`endif
      end
      default: d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/alu_bit_slice.sv
// Combinational 1-bit ALU slice with operand inversion, full-adder carry and less input.
module alu_bit_slice
  import alu_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       less,
  input  logic       A_invert,
  input  logic       B_invert,
  input  logic       cin,
  input  logic [1:0] op,
  output logic       result,
  output logic       cout
);

  logic aa;
  logic bb;

  assign aa   = a ^ A_invert;
  assign bb   = b ^ B_invert;
  assign cout = (aa & bb) | (aa & cin) | (bb & cin);

  always_comb begin
    result = 1'b0;
    case (op)
      OP_AND:  result = aa & bb;
      OP_OR:   result = aa | bb;
      OP_ADD:  result = aa ^ bb ^ cin;
      default: result = less;
    endcase
  end

endmodule

// File: rtl/alu_serial_ctrl.sv
// Bit-serial ALU sequencer: one WIDTH-bit operation through a 1-bit slice, LSB first.
// Optional feature macro: ALU_SERIAL_SLT_EN (SLT set-bit patch; otherwise 0111 acts as SUB).
module alu_serial_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             cout,
  output logic             overflow,
  output logic [1:0]       dbg_state
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  // Handshake: start is honoured only on an edge where state is IDLE; done pulses
  // for one cycle with result/flags valid, and they hold until the next accepted start.
  state_t state;
  state_t state_n;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic [CW-1:0]    count;
  logic             carry;
  dec_t             dec_q;
  logic             slice_res;
  logic             slice_cout;
  logic [WIDTH-1:0] res_fin;
  logic             ovf_fin;

`ifdef ALU_SERIAL_SLT_EN
  logic cin_msb_q;
  logic set_bit_q;
`else
  logic ovf_q;
`endif

  assign busy      = (state != IDLE);
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = RUN;
      RUN:     if (count == LAST) state_n = FIN;
      FIN:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  alu_bit_slice u_slice (
    .a        (a_sr[0]),
    .b        (b_sr[0]),
    .less     (1'b0),
    .A_invert (dec_q.a_inv),
    .B_invert (dec_q.b_inv),
    .cin      (carry),
    .op       (dec_q.op),
    .result   (slice_res),
    .cout     (slice_cout)
  );

  // After the MSB cycle, carry holds the carry out of the MSB.
  always_comb begin
    res_fin = res_sr;
    ovf_fin = 1'b0;
`ifdef ALU_SERIAL_SLT_EN
    ovf_fin = dec_q.arith & (cin_msb_q ^ carry);
    if (dec_q.slt) res_fin = {{(WIDTH-1){1'b0}}, set_bit_q};
`else
    ovf_fin = dec_q.arith & ovf_q;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr      <= '0;
      b_sr      <= '0;
      res_sr    <= '0;
      count     <= '0;
      carry     <= 1'b0;
      dec_q     <= '0;
      done      <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      cout      <= 1'b0;
      overflow  <= 1'b0;
`ifdef ALU_SERIAL_SLT_EN
      cin_msb_q <= 1'b0;
      set_bit_q <= 1'b0;
`else
      ovf_q     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_sr  <= src1;
            b_sr  <= src2;
            dec_q <= alu_decode(alu_ctrl);
            carry <= alu_decode(alu_ctrl).cin;
            count <= '0;
          end
        end
        RUN: begin
          res_sr <= {slice_res, res_sr[WIDTH-1:1]};
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          carry  <= slice_cout;
          if (count != LAST) begin
            count <= count + 1'b1;
          end else begin
`ifdef ALU_SERIAL_SLT_EN
            cin_msb_q <= carry;
            set_bit_q <= slice_res ^ carry ^ slice_cout;
`else
            ovf_q     <= carry ^ slice_cout;
`endif
          end
        end
        FIN: begin
          result   <= res_fin;
          zero     <= (res_fin == '0);
          cout     <= dec_q.arith & carry;
          overflow <= ovf_fin;
          done     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
